// File: rtl/mem_bus_arbiter.sv
// Byte-serial memory bus arbiter for the fetch and load/store ports.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_bus_arbiter #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_en,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_data,
    input  logic        ls_en,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_rdy,
    output logic [31:0] ls_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    typedef struct packed {
        logic        is_ls;
        logic        wr;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t          state, state_d;
    req_t            req, req_d, new_req;
    logic [2:0]      issue_idx, issue_idx_d;
    logic [2:0]      cap_idx, cap_idx_d;
    logic [1:0]      vld_pipe, vld_pipe_d;
    logic [3:0][7:0] rbuf, rbuf_d;
    logic [3:0][7:0] wbytes;
    logic [31:0]     issue_addr;

    logic [7:0]      mem_dout_d;
    logic [31:0]     mem_a_d;
    logic            mem_wr_d;
    logic            if_rdy_d, ls_rdy_d;
    logic [31:0]     if_data_d, ls_rdata_d;

    logic            pick_ls, ls_pref, stall, new_stall, go_idle;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last = 1 when the most recent grant went to load/store
    logic last, last_d;
    assign ls_pref = ~last;
`else
    assign ls_pref = 1'b1;
`endif

    assign pick_ls    = ls_en & (~if_en | ls_pref);
    assign wbytes     = req.wdata;
    assign issue_addr = req.addr + {29'd0, issue_idx};
    assign stall      = (req.addr[17:16] == IO_SEL) & io_buffer_full;
    assign new_stall  = (new_req.addr[17:16] == IO_SEL) & io_buffer_full;

    always_comb begin
        new_req.is_ls = pick_ls;
        new_req.wr    = pick_ls & ls_wr;
        new_req.addr  = pick_ls ? ls_addr : if_addr;
        new_req.wdata = ls_wdata;
        new_req.len   = 3'd4;
        if (pick_ls) begin
            case (ls_size)
                2'd0:    new_req.len = 3'd1;
                2'd1:    new_req.len = 3'd2;
                default: new_req.len = 3'd4;
            endcase
        end
    end

    always_comb begin
        state_d     = state;
        req_d       = req;
        issue_idx_d = issue_idx;
        cap_idx_d   = cap_idx;
        vld_pipe_d  = vld_pipe;
        rbuf_d      = rbuf;
        mem_dout_d  = mem_dout;
        mem_a_d     = mem_a;
        mem_wr_d    = 1'b0;
        if_rdy_d    = 1'b0;
        if_data_d   = if_data;
        ls_rdy_d    = 1'b0;
        ls_rdata_d  = ls_rdata;
        go_idle     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d      = last;
`endif

        case (state)
            IDLE: begin
                go_idle = 1'b1;
                if (rdy_in && !flush && (if_en || ls_en)) begin
                    go_idle     = 1'b0;
                    req_d       = new_req;
                    issue_idx_d = 3'd1;
                    cap_idx_d   = 3'd0;
                    rbuf_d      = '0;
                    mem_a_d     = '0;
                    mem_dout_d  = '0;
                    if_data_d   = '0;
                    ls_rdata_d  = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d      = pick_ls;
`endif
                    if (new_req.wr) begin
                        state_d = WR;
                        if (new_stall) begin
                            issue_idx_d = 3'd0;
                        end else begin
                            mem_a_d    = new_req.addr;
                            mem_dout_d = new_req.wdata[7:0];
                            mem_wr_d   = 1'b1;
                        end
                    end else begin
                        state_d    = RD;
                        mem_a_d    = new_req.addr;
                        vld_pipe_d = 2'b01;
                    end
                end
            end

            RD: begin
                if (flush) begin
                    go_idle = 1'b1;
                end else if (!rdy_in) begin
                    // bytes in flight are dropped; resume re-issues from the first uncaptured byte
                    vld_pipe_d  = 2'b00;
                    issue_idx_d = cap_idx;
                end else begin
                    vld_pipe_d = {vld_pipe[0], 1'b0};
                    if (vld_pipe[1]) begin
                        rbuf_d[cap_idx[1:0]] = mem_din;
                        cap_idx_d            = cap_idx + 3'd1;
                    end
                    if (issue_idx != req.len) begin
                        mem_a_d       = issue_addr;
                        issue_idx_d   = issue_idx + 3'd1;
                        vld_pipe_d[0] = 1'b1;
                    end
                    if (vld_pipe[1] && cap_idx == req.len - 3'd1) begin
                        state_d = DONE;
                        if (req.is_ls) begin
                            ls_rdy_d   = 1'b1;
                            ls_rdata_d = rbuf_d;
                        end else begin
                            if_rdy_d  = 1'b1;
                            if_data_d = rbuf_d;
                        end
                    end
                end
            end

            WR: begin
                // stores are committed, so flush has no effect here
                if (rdy_in) begin
                    if (issue_idx == req.len) begin
                        state_d  = DONE;
                        ls_rdy_d = 1'b1;
                    end else if (!stall) begin
                        mem_a_d     = issue_addr;
                        mem_dout_d  = wbytes[issue_idx[1:0]];
                        mem_wr_d    = 1'b1;
                        issue_idx_d = issue_idx + 3'd1;
                    end
                end
            end

            DONE: go_idle = 1'b1;

            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d    = IDLE;
            vld_pipe_d = 2'b00;
            mem_a_d    = '0;
            mem_dout_d = '0;
            mem_wr_d   = 1'b0;
            if_rdy_d   = 1'b0;
            ls_rdy_d   = 1'b0;
            if_data_d  = '0;
            ls_rdata_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            req       <= '0;
            issue_idx <= '0;
            cap_idx   <= '0;
            vld_pipe  <= '0;
            rbuf      <= '0;
            mem_dout  <= '0;
            mem_a     <= '0;
            mem_wr    <= 1'b0;
            if_rdy    <= 1'b0;
            if_data   <= '0;
            ls_rdy    <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            state     <= state_d;
            req       <= req_d;
            issue_idx <= issue_idx_d;
            cap_idx   <= cap_idx_d;
            vld_pipe  <= vld_pipe_d;
            rbuf      <= rbuf_d;
            mem_dout  <= mem_dout_d;
            mem_a     <= mem_a_d;
            mem_wr    <= mem_wr_d;
            if_rdy    <= if_rdy_d;
            if_data   <= if_data_d;
            ls_rdy    <= ls_rdy_d;
            ls_rdata  <= ls_rdata_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) last <= 1'b0;
        else           last <= last_d;
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed accesses, expected responses queued with their cycle.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, flush = 1'b0;
    logic [7:0]  mem_din = 8'h00, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full = 1'b0;
    logic        if_en = 1'b0, if_rdy;
    logic [31:0] if_addr = '0, if_data;
    logic        ls_en = 1'b0, ls_wr = 1'b0, ls_rdy;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rdata;

    mem_bus_arbiter dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
        .ls_en(ls_en), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdy(ls_rdy), .ls_rdata(ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [31:0] data; int cyc; bit st; } rsp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;

    rsp_t if_q[$], ls_q[$];
    wr_t  wr_q[$];
    int   checks = 0, errors = 0, cyc = 0;
    bit   last_ls = 1'b0;
    logic [7:0]  mem [0:4095];
    logic [31:0] addr_q = '0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // read data follows the address of the previous cycle
    always @(negedge clk_in) addr_q = mem_a;
    always @(posedge clk_in) begin
        #1 mem_din = mem[addr_q[11:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    rsp_t mr;
    wr_t  mw;
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (if_rdy) begin
                chk("if_rdy_expected", 32'(if_q.size() != 0), 32'd1);
                if (if_q.size() != 0) begin
                    mr = if_q.pop_front();
                    chk("if_data", if_data, mr.data);
                    chk("if_rdy_cycle", 32'(cyc), 32'(mr.cyc));
                end
            end
            if (ls_rdy) begin
                chk("ls_rdy_expected", 32'(ls_q.size() != 0), 32'd1);
                if (ls_q.size() != 0) begin
                    mr = ls_q.pop_front();
                    if (!mr.st) chk("ls_rdata", ls_rdata, mr.data);
                    chk("ls_rdy_cycle", 32'(cyc), 32'(mr.cyc));
                end
            end
            if (mem_wr) begin
                chk("mem_wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    mw = wr_q.pop_front();
                    chk("wr_addr", mem_a, mw.a);
                    chk("wr_data", {24'd0, mem_dout}, {24'd0, mw.d});
                    chk("wr_cycle", 32'(cyc), 32'(mw.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (if_rdy || ls_rdy) break;
        end
    endtask

    task automatic push_rsp(input bit is_ls, input logic [31:0] d, input int c, input bit st);
        rsp_t r;
        r.data = d; r.cyc = c; r.st = st;
        if (is_ls) ls_q.push_back(r);
        else       if_q.push_back(r);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int c);
        wr_t w;
        w.a = a; w.d = d; w.cyc = c;
        wr_q.push_back(w);
    endtask

    // four-byte store; the last two bytes are delayed by gap cycles
    task automatic push_wr4(input logic [31:0] a, input logic [31:0] wd, input int c0, input int gap);
        push_wr(a,         wd[7:0],   c0 + 1);
        push_wr(a + 32'd1, wd[15:8],  c0 + 2);
        push_wr(a + 32'd2, wd[23:16], c0 + 3 + gap);
        push_wr(a + 32'd3, wd[31:24], c0 + 4 + gap);
    endtask

    task automatic start_if(input logic [31:0] a);
        if_addr = a; if_en = 1'b1; last_ls = 1'b0;
    endtask

    task automatic start_ls(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_en = 1'b1; last_ls = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    int  c0;
    bit  ls_first;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h13; mem[12'h101] = 8'h05; mem[12'h102] = 8'h10; mem[12'h103] = 8'h00;
        mem[12'h000] = 8'hAA; mem[12'h001] = 8'hBB; mem[12'h002] = 8'h34; mem[12'h003] = 8'h12;
        mem[12'hFFF] = 8'h77;

        idle(2);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_rdy", {30'd0, if_rdy, ls_rdy}, 32'd0);
        chk("rst_data", if_data | ls_rdata, 32'd0);
        rst_n_in = 1'b1;
        idle(2);

        // word fetch with address sequence
        c0 = cyc;
        push_rsp(0, 32'h00100513, c0 + 6, 0);
        start_if(32'h100);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fetch_mem_a", mem_a, 32'h100 + 32'(i));
            chk("fetch_mem_wr", {31'd0, mem_wr}, 32'd0);
        end
        wait_rdy(); if_en = 1'b0;
        idle(2);

        // I/O byte store stalled three cycles
        c0 = cyc;
        push_wr(32'h30000, 8'hA5, c0 + 4);
        push_rsp(1, 32'd0, c0 + 5, 1);
        io_buffer_full = 1'b1;
        start_ls(1, 2'd0, 32'h30000, 32'h000000A5);
        idle(3);
        io_buffer_full = 1'b0;
        wait_rdy(); ls_en = 1'b0;
        idle(2);

        // plain word store
        c0 = cyc;
        push_wr4(32'h200, 32'hDEADBEEF, c0, 0);
        push_rsp(1, 32'd0, c0 + 5, 1);
        start_ls(1, 2'd2, 32'h200, 32'hDEADBEEF);
        wait_rdy(); ls_en = 1'b0;
        idle(2);

        // byte load, upper bytes zero
        c0 = cyc;
        push_rsp(1, 32'h00000013, c0 + 3, 0);
        start_ls(0, 2'd0, 32'h100, 32'd0);
        wait_rdy(); ls_en = 1'b0;
        idle(2);

        // word load wrapping past 0xFFFFFFFF
        c0 = cyc;
        push_rsp(1, 32'h34BBAA77, c0 + 6, 0);
        start_ls(0, 2'd3, 32'hFFFFFFFF, 32'd0);
        wait_rdy(); ls_en = 1'b0;
        idle(2);

        // flush in cycle 3 of a fetch: no if_rdy, idle next cycle
        c0 = cyc;
        start_if(32'h100);
        idle(3);
        flush = 1'b1; if_en = 1'b0;
        tick();
        flush = 1'b0;
        chk("flush_if_mem_a", mem_a, 32'd0);
        chk("flush_if_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("flush_if_rdy", {31'd0, if_rdy}, 32'd0);
        idle(8);

        // flush in cycle 2 of a word store: store completes
        c0 = cyc;
        push_wr4(32'h210, 32'h11223344, c0, 0);
        push_rsp(1, 32'd0, c0 + 5, 1);
        start_ls(1, 2'd2, 32'h210, 32'h11223344);
        idle(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_rdy(); ls_en = 1'b0;
        idle(2);

        // pause during cycles 2-4 of a word load: restart from byte 0
        c0 = cyc;
        push_rsp(1, 32'h00100513, c0 + 11, 0);
        start_ls(0, 2'd2, 32'h100, 32'd0);
        idle(2);
        rdy_in = 1'b0;
        idle(3);
        rdy_in = 1'b1;
        wait_rdy(); ls_en = 1'b0;
        idle(2);

        // pause during cycles 2-4 of a word store: each byte once
        c0 = cyc;
        push_wr4(32'h220, 32'hCAFEF00D, c0, 3);
        push_rsp(1, 32'd0, c0 + 8, 1);
        start_ls(1, 2'd2, 32'h220, 32'hCAFEF00D);
        idle(2);
        rdy_in = 1'b0;
        idle(3);
        rdy_in = 1'b1;
        wait_rdy(); ls_en = 1'b0;
        idle(2);

        // contention twice: half load at 0x2 against a word fetch
        for (int k = 0; k < 2; k++) begin
            c0 = cyc;
            ls_first = RR ? !last_ls : 1'b1;
            if (ls_first) begin
                push_rsp(1, 32'h00001234, c0 + 4, 0);
                push_rsp(0, 32'h00100513, c0 + 11, 0);
            end else begin
                push_rsp(0, 32'h00100513, c0 + 6, 0);
                push_rsp(1, 32'h00001234, c0 + 11, 0);
            end
            start_if(32'h100);
            start_ls(0, 2'd1, 32'h2, 32'd0);
            for (int i = 0; i < 40; i++) begin
                tick();
                if (ls_rdy) ls_en = 1'b0;
                if (if_rdy) if_en = 1'b0;
                if (!ls_en && !if_en) break;
            end
            ls_en = 1'b0; if_en = 1'b0;
            last_ls = !ls_first;
            idle(2);
        end

        // asynchronous reset in the middle of a word store
        c0 = cyc;
        push_wr(32'h230, 8'h88, c0 + 1);
        push_wr(32'h231, 8'h77, c0 + 2);
        start_ls(1, 2'd2, 32'h230, 32'h55667788);
        idle(3);
        rst_n_in = 1'b0;
        #1;
        chk("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("arst_mem_a", mem_a, 32'd0);
        chk("arst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("arst_ls_rdy", {31'd0, ls_rdy}, 32'd0);
        ls_en = 1'b0; last_ls = 1'b0;
        idle(2);
        rst_n_in = 1'b1;
        idle(2);
        chk("post_rst_mem_a", mem_a, 32'd0);
        chk("post_rst_mem_wr", {31'd0, mem_wr}, 32'd0);

        // block is usable again after reset
        c0 = cyc;
        push_rsp(0, 32'h00100513, c0 + 6, 0);
        start_if(32'h100);
        wait_rdy(); if_en = 1'b0;
        idle(5);

        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("ls_q_drained", 32'(ls_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
